// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encodings, coin values and payout FSM states.
// The coin codes match the encoding used on the vending FSM coin inputs.
package vend_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_5    = 2'b01;
    localparam coin_t COIN_10   = 2'b10;
    localparam coin_t COIN_25   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EJECT  = 2'd2,
        ST_DONE   = 2'd3
    } pay_state_e;

    // Face value of a coin code in 5c units.
    function automatic logic [2:0] coin_value(input coin_t code);
        logic [2:0] val;
        case (code)
            COIN_5:  val = 3'd1;
            COIN_10: val = 3'd2;
            COIN_25: val = 3'd5;
            default: val = 3'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin chooser: largest coin that fits the remaining amount and is in stock.
// Purely combinational; the payout controller registers the result.
module coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [CNT_W-1:0] inv5,
    input  logic [CNT_W-1:0] inv10,
    input  logic [CNT_W-1:0] inv25,
    output coin_t            code,
    output logic             found
);

    localparam logic [AMT_W-1:0] VAL_5  = AMT_W'(coin_value(COIN_5));
    localparam logic [AMT_W-1:0] VAL_10 = AMT_W'(coin_value(COIN_10));
    localparam logic [AMT_W-1:0] VAL_25 = AMT_W'(coin_value(COIN_25));

    // Priority search from the largest denomination down.
    always_comb begin
        code  = COIN_NONE;
        found = 1'b0;
        if ((remaining >= VAL_25) && (inv25 != {CNT_W{1'b0}})) begin
            code  = COIN_25;
            found = 1'b1;
        end else if ((remaining >= VAL_10) && (inv10 != {CNT_W{1'b0}})) begin
            code  = COIN_10;
            found = 1'b1;
        end else if ((remaining >= VAL_5) && (inv5 != {CNT_W{1'b0}})) begin
            code  = COIN_5;
            found = 1'b1;
        end else begin
            code  = COIN_NONE;
            found = 1'b0;
        end
    end

endmodule

// File: rtl/change_payout_ctrl.sv
// Change payout sequencer: pays an amount greedily one coin per ejector handshake,
// tracks tube inventory and flags shortfall or ejector jam.
module change_payout_ctrl
    import vend_pkg::*;
#(
    parameter int AMT_W       = 4,
    parameter int CNT_W       = 4,
    parameter int INIT_CNT    = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             refill_en,
    input  logic [1:0]       refill_denom,
    input  logic [CNT_W-1:0] refill_cnt,
    input  logic             eject_ack,
    output logic             eject_valid,
    output logic [1:0]       eject_coin,
    output logic             busy,
    output logic             done,
    output logic             err_short,
    output logic             err_jam,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] inv5,
    output logic [CNT_W-1:0] inv10,
    output logic [CNT_W-1:0] inv25
);

    localparam int               TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] INV_INIT = CNT_W'(INIT_CNT);

    pay_state_e       state_r, state_s;
    logic [AMT_W-1:0] remaining_r, remaining_s;
    logic [TMO_W-1:0] tmo_r, tmo_s;
    logic [CNT_W-1:0] inv5_r, inv10_r, inv25_r;
    logic [CNT_W-1:0] inv5_s, inv10_s, inv25_s;
    logic             eject_valid_r, eject_valid_s;
    coin_t            eject_coin_r, eject_coin_s;
    logic             busy_r, done_r, err_short_r, err_jam_r;
    logic             done_s, err_short_s, err_jam_s;
    coin_t            sel_code_s;
    logic             sel_found_s;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    coin_select #(
        .AMT_W (AMT_W),
        .CNT_W (CNT_W)
    ) u_coin_select (
        .remaining (remaining_r),
        .inv5      (inv5_r),
        .inv10     (inv10_r),
        .inv25     (inv25_r),
        .code      (sel_code_s),
        .found     (sel_found_s)
    );

    // Next-state, next-output and inventory update logic.
    always_comb begin
        state_s       = state_r;
        remaining_s   = remaining_r;
        tmo_s         = tmo_r;
        inv5_s        = inv5_r;
        inv10_s       = inv10_r;
        inv25_s       = inv25_r;
        eject_valid_s = 1'b0;
        eject_coin_s  = COIN_NONE;
        err_short_s   = 1'b0;
        err_jam_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Refill lands on the same edge as start, so SELECT sees it.
                if (refill_en) begin
                    case (refill_denom)
                        COIN_5:  inv5_s  = sat_add(inv5_r, refill_cnt);
                        COIN_10: inv10_s = sat_add(inv10_r, refill_cnt);
                        COIN_25: inv25_s = sat_add(inv25_r, refill_cnt);
                        default: inv5_s  = inv5_r;
                    endcase
                end else begin
                    inv5_s = inv5_r;
                end
                if (start) begin
                    remaining_s = amount;
                    tmo_s       = {TMO_W{1'b0}};
                    if (amount == {AMT_W{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SELECT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (sel_found_s) begin
                    state_s       = ST_EJECT;
                    eject_valid_s = 1'b1;
                    eject_coin_s  = sel_code_s;
                end else if (remaining_r != {AMT_W{1'b0}}) begin
                    state_s     = ST_DONE;
                    err_short_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_EJECT: begin
                if (eject_ack) begin
                    remaining_s = remaining_r - AMT_W'(coin_value(eject_coin_r));
                    case (eject_coin_r)
                        COIN_5:  inv5_s  = inv5_r - CNT_W'(1);
                        COIN_10: inv10_s = inv10_r - CNT_W'(1);
                        COIN_25: inv25_s = inv25_r - CNT_W'(1);
                        default: inv5_s  = inv5_r;
                    endcase
                    tmo_s   = {TMO_W{1'b0}};
                    state_s = ST_SELECT;
                end else if (tmo_r == TMO_LAST) begin
                    // Timeout: leave remaining and inventory untouched.
                    tmo_s     = {TMO_W{1'b0}};
                    state_s   = ST_DONE;
                    err_jam_s = 1'b1;
                end else begin
                    tmo_s         = tmo_r + TMO_W'(1);
                    eject_valid_s = 1'b1;
                    eject_coin_s  = eject_coin_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        done_s = (state_s == ST_DONE);
    end

    // State, inventory and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            remaining_r   <= {AMT_W{1'b0}};
            tmo_r         <= {TMO_W{1'b0}};
            inv5_r        <= INV_INIT;
            inv10_r       <= INV_INIT;
            inv25_r       <= INV_INIT;
            eject_valid_r <= 1'b0;
            eject_coin_r  <= COIN_NONE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_short_r   <= 1'b0;
            err_jam_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            remaining_r   <= remaining_s;
            tmo_r         <= tmo_s;
            inv5_r        <= inv5_s;
            inv10_r       <= inv10_s;
            inv25_r       <= inv25_s;
            eject_valid_r <= eject_valid_s;
            eject_coin_r  <= eject_coin_s;
            busy_r        <= (state_s != ST_IDLE);
            done_r        <= done_s;
            err_short_r   <= err_short_s;
            err_jam_r     <= err_jam_s;
        end
    end

    assign eject_valid = eject_valid_r;
    assign eject_coin  = eject_coin_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_short   = err_short_r;
    assign err_jam     = err_jam_r;
    assign remaining   = remaining_r;
    assign inv5        = inv5_r;
    assign inv10       = inv10_r;
    assign inv25       = inv25_r;

endmodule
